// File: rtl/arb_pkg.sv
// Shared types and widths for the CPU/DMA memory-bus arbiter.
package arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DMA  = 2'd1,
    S_COOL = 2'd2
  } arb_state_e;

  // Bits needed to count 0..n-1; a one-value window still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_window_counter.sv
// Up-counter over a window of LIMIT values with synchronous clear, enable and
// terminal-count flag; wraps to zero when it advances past LIMIT-1.
module arb_window_counter
  import arb_pkg::*;
#(
  parameter int LIMIT = 16,
  parameter int W     = cnt_width(LIMIT)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] count_q, count_d;

  assign tc_o = (count_q == W'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU core and a DMA requester with bounded
// bursts and a forced CPU window. Optional stall counter: define ARB_STATS_EN.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CPU_MIN   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              locked,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_in,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_in
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stall_count
`endif
);

  arb_state_e state_q, state_d;
  logic       bus_active;
  logic       beat;
  logic       burst_tc;
  logic       cool_tc;

  assign bus_active = locked & reset_n;
  assign beat       = bus_active & (state_q == S_DMA) & dma_req;

  arb_window_counter #(.LIMIT(MAX_BURST)) u_burst (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (state_q != S_DMA),
    .en_i    (beat),
    .tc_o    (burst_tc)
  );

  arb_window_counter #(.LIMIT(CPU_MIN)) u_cool (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (state_q != S_COOL),
    .en_i    (bus_active & (state_q == S_COOL)),
    .tc_o    (cool_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CPU:   if (dma_req) state_d = S_DMA;
      S_DMA: begin
        if (!dma_req) begin
          state_d = S_CPU;
        end else if (burst_tc) begin
          state_d = S_COOL;
        end
      end
      S_COOL:  if (cool_tc) state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
    // A lost PLL lock freezes ownership exactly where it is.
    if (!locked) state_d = state_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // The frozen core's write strobe is dropped while DMA owns the bus.
  always_comb begin
    mem_addr = '0;
    mem_out  = '0;
    mem_we   = 1'b0;
    if (bus_active) begin
      if (state_q == S_DMA) begin
        mem_addr = dma_addr;
        mem_out  = dma_wdata;
        mem_we   = dma_req & dma_we;
      end else begin
        mem_addr = cpu_addr;
        mem_out  = cpu_out;
        mem_we   = cpu_we;
      end
    end
  end

  assign cpu_en    = bus_active & (state_q != S_DMA);
  assign dma_ack   = beat;
  assign cpu_in    = mem_in;
  assign dma_rdata = mem_in;

`ifdef ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (locked && (state_q == S_DMA) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, multi-cycle
// burst/lock/reset sequences, and randomized traffic against an ownership model.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST = 16;
  localparam int CPU_MIN   = 4;
  localparam logic [19:0] CA = 20'h00C0D;
  localparam logic [7:0]  CO = 8'h3C;

  logic        clock = 1'b0;
  logic        reset_n, locked, cpu_en, cpu_we, dma_req, dma_we, dma_ack, mem_we;
  logic [19:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_out, cpu_in, dma_wdata, dma_rdata, mem_out, mem_in;
`ifdef ARB_STATS_EN
  logic [15:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_MIN(CPU_MIN)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .locked    (locked),
    .cpu_en    (cpu_en),
    .cpu_addr  (cpu_addr),
    .cpu_out   (cpu_out),
    .cpu_we    (cpu_we),
    .cpu_in    (cpu_in),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_addr  (mem_addr),
    .mem_out   (mem_out),
    .mem_we    (mem_we),
    .mem_in    (mem_in)
`ifdef ARB_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  typedef struct {
    logic        rst, lck, req, dwe, cwe;
    logic [19:0] daddr;
    logic [7:0]  dwd;
    logic        ex_en, ex_ack, ex_we;
    logic [19:0] ex_addr;
    logic [7:0]  ex_out;
  } vec_t;

  vec_t tbl[13];

  // Ownership model: who holds the bus, beats taken, CPU cycles still owed.
  bit m_dma;
  int m_beats, m_owed, m_stall;

  function automatic vec_t mk(input logic r, l, q, dw, cw, input logic [19:0] da,
                              input logic [7:0] dd, input logic e, a, w,
                              input logic [19:0] ea, input logic [7:0] eo);
    vec_t v;
    v.rst = r; v.lck = l; v.req = q; v.dwe = dw; v.cwe = cw; v.daddr = da; v.dwd = dd;
    v.ex_en = e; v.ex_ack = a; v.ex_we = w; v.ex_addr = ea; v.ex_out = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled on the falling edge.
  task automatic drive(input logic r, l, q, dw, cw, input logic [19:0] da,
                       input logic [7:0] dd, input logic [19:0] ca, input logic [7:0] co);
    @(posedge clock);
    #1;
    reset_n = r; locked = l; dma_req = q; dma_we = dw; cpu_we = cw;
    dma_addr = da; dma_wdata = dd; cpu_addr = ca; cpu_out = co;
    mem_in = 8'($urandom);
    @(negedge clock);
  endtask

  task automatic simple(input logic r, l, q);
    drive(r, l, q, 1'b0, 1'b0, 20'h0_1000, 8'h00, CA, CO);
  endtask

  task automatic model_update(input logic r, l, q);
    if (!r) begin
      m_dma = 0; m_beats = 0; m_owed = 0; m_stall = 0;
    end else if (l) begin
      if (m_dma && m_stall < 65535) m_stall++;
      if (m_dma) begin
        if (q) begin
          m_beats++;
          if (m_beats == MAX_BURST) begin
            m_dma = 0; m_beats = 0; m_owed = CPU_MIN;
          end
        end else begin
          m_dma = 0; m_beats = 0;
        end
      end else if (m_owed > 0) begin
        m_owed--;
      end else if (q) begin
        m_dma = 1; m_beats = 0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, k;
    logic exp_ack;
    reset_n = 0; locked = 1; dma_req = 0; dma_we = 0; cpu_we = 0;
    dma_addr = '0; dma_wdata = '0; cpu_addr = CA; cpu_out = CO; mem_in = '0;

    // Directed table: reset, single read, DMA write with CPU write held, lock loss.
    tbl[0]  = mk(0,1,0,0,0, 20'h12345, 8'h00, 0,0,0, 20'h0,     8'h00);
    tbl[1]  = mk(0,1,1,0,1, 20'h12345, 8'h00, 0,0,0, 20'h0,     8'h00);
    tbl[2]  = mk(1,1,0,0,1, 20'h12345, 8'h00, 1,0,1, CA,        CO);
    tbl[3]  = mk(1,1,1,0,0, 20'h12345, 8'h00, 1,0,0, CA,        CO);
    tbl[4]  = mk(1,1,1,0,0, 20'h12345, 8'h00, 0,1,0, 20'h12345, 8'h00);
    tbl[5]  = mk(1,1,0,0,0, 20'h12345, 8'h00, 0,0,0, 20'h12345, 8'h00);
    tbl[6]  = mk(1,1,0,0,0, 20'h12345, 8'h00, 1,0,0, CA,        CO);
    tbl[7]  = mk(1,1,1,1,1, 20'hB8000, 8'hA5, 1,0,1, CA,        CO);
    tbl[8]  = mk(1,1,1,1,1, 20'hB8000, 8'hA5, 0,1,1, 20'hB8000, 8'hA5);
    tbl[9]  = mk(1,1,0,1,1, 20'hB8000, 8'hA5, 0,0,0, 20'hB8000, 8'hA5);
    tbl[10] = mk(1,1,0,0,1, 20'hB8000, 8'hA5, 1,0,1, CA,        CO);
    tbl[11] = mk(1,0,1,0,1, 20'hB8000, 8'hA5, 0,0,0, 20'h0,     8'h00);
    tbl[12] = mk(1,1,0,0,1, 20'hB8000, 8'hA5, 1,0,1, CA,        CO);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].lck, tbl[i].req, tbl[i].dwe, tbl[i].cwe,
            tbl[i].daddr, tbl[i].dwd, CA, CO);
      check($sformatf("tbl%0d_ctl", i), {61'd0, cpu_en, dma_ack, mem_we},
            {61'd0, tbl[i].ex_en, tbl[i].ex_ack, tbl[i].ex_we});
      check($sformatf("tbl%0d_bus", i), {36'd0, mem_addr, mem_out},
            {36'd0, tbl[i].ex_addr, tbl[i].ex_out});
      check($sformatf("tbl%0d_rdata", i), {48'd0, cpu_in, dma_rdata}, {48'd0, mem_in, mem_in});
    end

    // Held request: bursts of MAX_BURST beats separated by the CPU window plus
    // the one-cycle request latency, until 40 beats have been served.
    simple(0, 1, 0);
`ifdef ARB_STATS_EN
    check("stall_after_reset", {48'd0, stall_count}, 64'd0);
`endif
    acks = 0; k = 0;
    while (acks < 40 && k < 200) begin
      simple(1, 1, 1);
      exp_ack = (k != 0) && (((k - 1) % (MAX_BURST + CPU_MIN + 1)) < MAX_BURST);
      check($sformatf("burst_ack%0d", k), {63'd0, dma_ack}, {63'd0, exp_ack});
      check($sformatf("burst_en%0d", k), {63'd0, cpu_en}, {63'd0, ~exp_ack});
      if (dma_ack) acks++;
      k++;
    end
    check("burst_cycles", 64'(k), 64'(1 + 16 + 5 + 16 + 5 + 8));
    simple(1, 1, 0);
`ifdef ARB_STATS_EN
    check("stall_after_burst", {48'd0, stall_count}, 64'd40);
`endif
    simple(1, 1, 0);
    check("burst_release_en", {63'd0, cpu_en}, 64'd1);

    // Lock loss at beat 5 stalls the burst without losing its position.
    simple(0, 1, 0);
    simple(1, 1, 1);
    check("lock_req_cycle", {62'd0, dma_ack, cpu_en}, {62'd0, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) begin
      simple(1, 1, 1);
      check($sformatf("lock_pre%0d", i), {63'd0, dma_ack}, 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      simple(1, 0, 1);
      check($sformatf("lock_low%0d", i), {61'd0, dma_ack, cpu_en, mem_we}, 64'd0);
    end
    for (int i = 0; i < 11; i++) begin
      simple(1, 1, 1);
      check($sformatf("lock_post%0d", i), {62'd0, dma_ack, cpu_en}, {62'd0, 1'b1, 1'b0});
    end
    simple(1, 1, 1);
    check("lock_cool", {62'd0, dma_ack, cpu_en}, {62'd0, 1'b0, 1'b1});
    for (int i = 0; i < CPU_MIN + 1; i++) simple(1, 1, 0);

    // Reset in the middle of a burst discards the partial burst.
    simple(1, 1, 1);
    for (int i = 0; i < 7; i++) begin
      simple(1, 1, 1);
      check($sformatf("rst_pre%0d", i), {63'd0, dma_ack}, 64'd1);
    end
    simple(0, 1, 1);
    check("rst_cycle", {61'd0, dma_ack, cpu_en, mem_we}, 64'd0);
    simple(1, 1, 1);
    check("rst_release", {62'd0, dma_ack, cpu_en}, {62'd0, 1'b0, 1'b1});
    for (int i = 0; i < MAX_BURST; i++) begin
      simple(1, 1, 1);
      check($sformatf("rst_full%0d", i), {63'd0, dma_ack}, 64'd1);
    end
    simple(1, 1, 1);
    check("rst_cool", {62'd0, dma_ack, cpu_en}, {62'd0, 1'b0, 1'b1});

    // Randomized traffic against the ownership model.
    simple(0, 1, 0);
    model_update(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic r, l, q, dw, cw;
      logic [19:0] da, ca;
      logic [7:0] dd, co;
      logic e_en, e_ack, e_we, act;
      logic [19:0] e_addr;
      logic [7:0] e_out;
      r  = ($urandom_range(0, 99) != 0);
      l  = ($urandom_range(0, 9) != 0);
      q  = ($urandom_range(0, 9) < 7);
      dw = 1'($urandom); cw = 1'($urandom);
      da = 20'($urandom); ca = 20'($urandom);
      dd = 8'($urandom);  co = 8'($urandom);
      drive(r, l, q, dw, cw, da, dd, ca, co);
      act    = r & l;
      e_en   = act & !m_dma;
      e_ack  = act & m_dma & q;
      e_we   = act & (m_dma ? (q & dw) : cw);
      e_addr = !act ? 20'h0 : (m_dma ? da : ca);
      e_out  = !act ? 8'h00 : (m_dma ? dd : co);
      check($sformatf("rand%0d", i),
            {20'd0, cpu_en, dma_ack, mem_we, mem_addr, mem_out, cpu_in, dma_rdata},
            {20'd0, e_en, e_ack, e_we, e_addr, e_out, mem_in, mem_in});
`ifdef ARB_STATS_EN
      check($sformatf("rand_stall%0d", i), {48'd0, stall_count}, 64'(m_stall));
`endif
      model_update(r, l, q);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
